// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle RV32I datapath: owns the datapath reset and run enable,
// sequences free-run / single-step execution and stops on EBREAK, halt request or timeout.
module cpu_run_controller #(
    parameter int IM_L       = 16,
    parameter int CNT_W      = 32,
    parameter int MAX_INSTR  = 1000,
    parameter int RST_CYCLES = 2,
    localparam int PW        = $clog2(IM_L*4)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_req,
    input  logic [31:0]      im_data,
    input  logic [PW-1:0]    pc,
    output logic             dp_rst,
    output logic             dp_run,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count,
    output logic [PW-1:0]    halt_pc
);
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_RUN, S_STEP, S_PAUSE, S_DONE, S_TIMEOUT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    hpc_q, hpc_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;

    logic             brk;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_hit;
    logic [PW-1:0]    pc_nxt;
    logic             unused_im;

    assign brk       = (im_data[6:0] == 7'b1110011);
    assign unused_im = ^im_data[31:7];
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign cnt_hit   = (cnt_inc == CNT_W'(MAX_INSTR));
    assign pc_nxt    = pc + PW'(4);

    // dp_run is gated by brk combinationally so the PC never steps past an EBREAK.
    assign dp_run      = ((state_q == S_RUN) || (state_q == S_STEP)) && !brk;
    assign dp_rst      = (state_q == S_IDLE) || (state_q == S_RESET);
    assign busy        = (state_q == S_RESET) || (state_q == S_RUN) ||
                         (state_q == S_STEP)  || (state_q == S_PAUSE);
    assign paused      = (state_q == S_PAUSE);
    assign done        = (state_q == S_DONE);
    assign timeout     = (state_q == S_TIMEOUT);
    assign instr_count = cnt_q;
    assign halt_pc     = hpc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hpc_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hpc_q   <= hpc_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hpc_d   = hpc_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    hpc_d   = '0;
                    rcnt_d  = '0;
                end
            end
            S_RESET: begin
                if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                    rcnt_d  = '0;
                    state_d = step_mode ? S_PAUSE : S_RUN;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            S_RUN: begin
                // brk outranks timeout, which outranks halt_req.
                if (brk) begin
                    state_d = S_DONE;
                    hpc_d   = pc;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_hit) begin
                        state_d = S_TIMEOUT;
                        hpc_d   = pc_nxt;
                    end else if (halt_req) begin
                        state_d = S_PAUSE;
                        hpc_d   = pc_nxt;
                    end
                end
            end
            S_STEP: begin
                if (brk) begin
                    state_d = S_DONE;
                    hpc_d   = pc;
                end else begin
                    cnt_d   = cnt_inc;
                    hpc_d   = pc_nxt;
                    state_d = cnt_hit ? S_TIMEOUT : S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (start)     state_d = S_RUN;
                else if (step) state_d = S_STEP;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a tiny behavioural datapath (PC + program ROM).
module tb_cpu_run_controller;
    localparam int IM_L = 16;
    localparam int CNT_W = 32;
    localparam int PW = 6;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] JAL0 = 32'h0000_006F;

    logic             clk = 0;
    logic             rst = 0;
    logic             start = 0, step_mode = 0, step = 0, halt_req = 0;
    logic [31:0]      im_data;
    logic [PW-1:0]    pc;
    logic             dp_rst, dp_run, busy, paused, done, timeout;
    logic [CNT_W-1:0] instr_count;
    logic [PW-1:0]    halt_pc;
    logic [31:0]      prog [IM_L];

    int passed = 0;
    int total = 0;

    cpu_run_controller #(.IM_L(IM_L), .CNT_W(CNT_W), .MAX_INSTR(8), .RST_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .halt_req(halt_req), .im_data(im_data), .pc(pc), .dp_rst(dp_rst), .dp_run(dp_run),
        .busy(busy), .paused(paused), .done(done), .timeout(timeout),
        .instr_count(instr_count), .halt_pc(halt_pc)
    );

    always #5 clk = ~clk;

    // Datapath model: jal x0,0 spins in place, anything else falls through.
    assign im_data = prog[pc[PW-1:2]];
    always_ff @(posedge clk) begin
        if (dp_rst)      pc <= '0;
        else if (dp_run) pc <= (im_data[6:0] == 7'b1101111) ? pc : pc + PW'(4);
    end

    task automatic load_linear();
        for (int i = 0; i < IM_L; i++) prog[i] = EBRK;
        for (int i = 0; i < 5; i++) prog[i] = NOP;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic test_reset();
        load_linear();
        rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({dp_rst, dp_run, busy, paused, done, timeout} !== 6'b100000)
            $display("FAIL reset_flags: got %b want 100000", {dp_rst, dp_run, busy, paused, done, timeout});
        else passed++;
        total++; if (instr_count !== 0 || halt_pc !== 0)
            $display("FAIL reset_regs: got cnt=%0d hpc=%0d want 0/0", instr_count, halt_pc);
        else passed++;
        #1 rst = 1;
    endtask

    task automatic test_free_run();
        int nrst = 0, nrun = 0;
        bit got = 0;
        load_linear();
        step_mode = 0;
        pulse_start();
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (dp_rst) nrst++;
            if (dp_run) nrun++;
            if (done) got = 1;
        end
        total++; if (!got) $display("FAIL free_done: got done=0 want 1 within budget"); else passed++;
        total++; if (nrst != 2) $display("FAIL free_rst_cycles: got %0d want 2", nrst); else passed++;
        total++; if (nrun != 5) $display("FAIL free_run_cycles: got %0d want 5", nrun); else passed++;
        total++; if (instr_count !== 5 || halt_pc !== 20)
            $display("FAIL free_result: got cnt=%0d hpc=%0d want 5/20", instr_count, halt_pc);
        else passed++;
        repeat (3) @(negedge clk);
        total++; if (dp_run !== 0 || pc !== 20 || instr_count !== 5 || busy !== 0)
            $display("FAIL free_hold: got run=%0d pc=%0d cnt=%0d busy=%0d want 0/20/5/0",
                     dp_run, pc, instr_count, busy);
        else passed++;
    endtask

    task automatic test_single_step();
        bit got = 0;
        step_mode = 1;
        pulse_start();
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (paused) got = 1;
        end
        total++; if (!got || instr_count !== 0 || dp_run !== 0)
            $display("FAIL step_enter_pause: got paused=%0d cnt=%0d want 1/0", paused, instr_count);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 step = 1;
            @(posedge clk); #1 step = 0;
            @(posedge clk);
        end
        @(negedge clk);
        total++; if (instr_count !== 3 || halt_pc !== 12 || paused !== 1 || pc !== 12)
            $display("FAIL step_three: got cnt=%0d hpc=%0d paused=%0d pc=%0d want 3/12/1/12",
                     instr_count, halt_pc, paused, pc);
        else passed++;
        step_mode = 0;
        pulse_start();
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        total++; if (!got || instr_count !== 5 || halt_pc !== 20)
            $display("FAIL step_resume_done: got done=%0d cnt=%0d hpc=%0d want 1/5/20",
                     done, instr_count, halt_pc);
        else passed++;
    endtask

    task automatic test_halt_req();
        bit got = 0;
        for (int i = 0; i < IM_L; i++) prog[i] = JAL0;
        step_mode = 0;
        pulse_start();
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (instr_count == 4) got = 1;
        end
        halt_req = 1;
        @(posedge clk); #1 halt_req = 0;
        @(negedge clk);
        total++; if (!got || paused !== 1 || instr_count !== 5 || dp_run !== 0 || halt_pc !== 4)
            $display("FAIL halt_pause: got paused=%0d cnt=%0d run=%0d hpc=%0d want 1/5/0/4",
                     paused, instr_count, dp_run, halt_pc);
        else passed++;
        pulse_start();
        @(negedge clk);
        total++; if (dp_run !== 1 || instr_count !== 5)
            $display("FAIL halt_resume: got run=%0d cnt=%0d want 1/5", dp_run, instr_count);
        else passed++;
        @(negedge clk);
        total++; if (instr_count !== 6)
            $display("FAIL halt_count_on: got %0d want 6", instr_count);
        else passed++;
    endtask

    task automatic test_timeout();
        bit got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (timeout) got = 1;
        end
        total++; if (!got || instr_count !== 8 || busy !== 0 || dp_run !== 0 || halt_pc !== 4)
            $display("FAIL timeout_hit: got to=%0d cnt=%0d busy=%0d run=%0d hpc=%0d want 1/8/0/0/4",
                     timeout, instr_count, busy, dp_run, halt_pc);
        else passed++;
        pulse_start();
        @(negedge clk);
        total++; if (instr_count !== 0 || dp_rst !== 1 || busy !== 1 || timeout !== 0)
            $display("FAIL timeout_restart: got cnt=%0d rst=%0d busy=%0d to=%0d want 0/1/1/0",
                     instr_count, dp_rst, busy, timeout);
        else passed++;
    endtask

    task automatic test_async_reset();
        bit got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (instr_count == 3) got = 1;
        end
        total++; if (!got || dp_run !== 1)
            $display("FAIL async_pre: got cnt=%0d run=%0d want 3/1", instr_count, dp_run);
        else passed++;
        #1 rst = 0;
        #1;
        total++; if (dp_rst !== 1 || dp_run !== 0 || instr_count !== 0 || busy !== 0 || halt_pc !== 0)
            $display("FAIL async_reset: got rst=%0d run=%0d cnt=%0d busy=%0d hpc=%0d want 1/0/0/0/0",
                     dp_rst, dp_run, instr_count, busy, halt_pc);
        else passed++;
        @(posedge clk); #1 rst = 1;
    endtask

    task automatic test_first_ebreak();
        bit got = 0, ran = 0;
        for (int i = 0; i < IM_L; i++) prog[i] = EBRK;
        step_mode = 0;
        pulse_start();
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (dp_run) ran = 1;
            if (done) got = 1;
        end
        total++; if (!got || ran || instr_count !== 0 || halt_pc !== 0)
            $display("FAIL first_ebreak: got done=%0d ran=%0d cnt=%0d hpc=%0d want 1/0/0/0",
                     done, ran, instr_count, halt_pc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_single_step();
        test_halt_req();
        test_timeout();
        test_async_reset();
        test_first_ebreak();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the single-cycle RV32I datapath. Drives the datapath's synchronous reset and its run enable.
- Supports free-run and single-step execution.
- Stops on EBREAK (opcode 7'b1110011), on an external halt request, or on an instruction-count timeout.
- Reports the halt PC and the retired-instruction count to the testbench/debug host. Sits between the top level and the datapath's rst/run inputs.

Parameters:
- IM_L, 16, instruction memory depth in words; PC width PW = $clog2(IM_L*4).
- CNT_W, 32, width of instr_count.
- MAX_INSTR, 1000, instructions retired before forced TIMEOUT (must be ≥1 and < 2^CNT_W).
- RST_CYCLES, 2, cycles dp_rst is held high in RESET (≥1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: start from IDLE/DONE/TIMEOUT; resume from PAUSE.
- step_mode, input, 1: sampled on leaving RESET. 1 = enter PAUSE; 0 = enter RUN.
- step, input, 1: execute exactly one instruction while in PAUSE.
- halt_req, input, 1: request pause while in RUN.
- im_data, input, 32: current instruction from instruction memory.
- pc, input, PW: datapath PC (im_addr).
- dp_rst, output, 1: synchronous reset to the datapath, active high.
- dp_run, output, 1: run enable to the datapath.
- busy, output, 1: state is RESET, RUN, STEP or PAUSE.
- paused, output, 1: state is PAUSE.
- done, output, 1: state is DONE.
- timeout, output, 1: state is TIMEOUT.
- instr_count, output, CNT_W: instructions retired since the last start from IDLE/DONE/TIMEOUT.
- halt_pc, output, PW: pc captured at EBREAK, timeout or pause entry.

Behaviour:
- States: IDLE, RESET, RUN, STEP, PAUSE, DONE, TIMEOUT. Registered state. dp_rst, busy, paused, done and timeout decode combinationally from state.
- Asynchronous reset (rst=0):
  - state=IDLE; instr_count=0; halt_pc=0; RESET counter=0.
  - Outputs: dp_rst=1, dp_run=0, busy=0, paused=0, done=0, timeout=0.
- brk = (im_data[6:0]==7'b1110011).
- dp_run = (state==RUN || state==STEP) && !brk. It is combinational, so the PC never advances past an EBREAK.
- dp_rst = 1 in IDLE and RESET, 0 elsewhere.
- Retire event: ret = dp_run. On each ret edge, instr_count += 1. instr_count never wraps; MAX_INSTR guarantees this.
- IDLE: start → RESET. Clear instr_count and halt_pc.
- RESET:
  - Count RST_CYCLES cycles, then → PAUSE if step_mode=1, else → RUN.
  - start, step and halt_req are ignored in RESET.
- RUN, priority per cycle: brk > timeout > halt_req.
  - brk → DONE, halt_pc <= pc; no retire.
  - ret && instr_count+1 == MAX_INSTR → TIMEOUT, halt_pc <= pc+4 (PW-bit wrap). The instruction retires and the count becomes MAX_INSTR.
  - halt_req → PAUSE, halt_pc <= pc+4. The instruction presented this cycle still retires.
- PAUSE: dp_run=0.
  - start → RUN.
  - Else step → STEP.
  - start takes priority over step.
- STEP: lasts exactly one cycle.
  - brk → DONE, halt_pc <= pc.
  - Else retire; → TIMEOUT if the count reaches MAX_INSTR, otherwise → PAUSE with halt_pc <= pc+4.
  - A step held high re-enters STEP only after a return to PAUSE, giving one instruction per two cycles. The bench pulses step.
- DONE/TIMEOUT:
  - Hold instr_count and halt_pc. dp_run=0.
  - start → RESET, which clears the counters and restarts the program at PC 0.
- rst asserted mid-operation (any state): immediate IDLE and all reset values. The datapath is held in reset via dp_rst=1.
- All inputs are synchronous to clk. Level-sensitive inputs are acted on at the rising edge.

Test Plan:
1. Free run, program of 5 instructions then EBREAK at PC 20, step_mode=0: start pulse → dp_rst high 2 cycles, then dp_run high 5 cycles. Then done=1, instr_count=5, halt_pc=20, dp_run=0 while pc holds at 20.
2. Single step, same program, step_mode=1: after RESET, paused=1. Three step pulses → instr_count=3, halt_pc=12, paused=1. start → runs to DONE with instr_count=5.
3. Halt request: infinite loop (jal x0,0 at PC 0), halt_req pulsed in RUN after 4 retirements → PAUSE with instr_count=5, dp_run=0. start resumes; instr_count keeps incrementing.
4. Timeout: MAX_INSTR=8, infinite loop → timeout=1, instr_count=8, busy=0. A further start → RESET, instr_count=0.
5. Async reset mid-RUN at instr_count=3: rst low between edges → state=IDLE, dp_rst=1, dp_run=0, instr_count=0 immediately, without waiting for a clock edge.
6. EBREAK as the first instruction (PC 0): start → DONE directly after RESET, instr_count=0, halt_pc=0, dp_run never asserted.
